// File: rtl/depth_test_writer_pkg.sv
`default_nettype none
// =============================================================================
// depth_test_writer_pkg: shared graphics types, clear value, FSM encoding.
// Rev 1.0
// =============================================================================
package depth_test_writer_pkg;

   localparam int DEPTH_W = 16;
   localparam int COLOR_W = 16;

   typedef logic [DEPTH_W-1:0] depth_t;
   typedef logic [COLOR_W-1:0] color_t;

   localparam depth_t DEPTH_CLEAR = '1;

   function automatic int fb_addr_width(input int w, input int h);
      return (w * h > 1) ? $clog2(w * h) : 1;
   endfunction

   localparam int FB_ADDR_W = fb_addr_width(320, 180);
   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/depth_test_writer_if.sv
`default_nettype none
// =============================================================================
// depth_test_writer_if: pixel stream, clear control and BRAM port bundle.
// Rev 1.0
// =============================================================================
interface depth_test_writer_if
   import depth_test_writer_pkg::*;
#(
   parameter int COORD_WIDTH     = 32,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int COLOR_WIDTH     = 16,
   parameter int FB_WIDTH        = 320,
   parameter int FB_HEIGHT       = 180
);
   localparam int ADDR_WIDTH = fb_addr_width(FB_WIDTH, FB_HEIGHT);

   // x_in/y_in carry two's-complement coordinates
   logic                       pixel_valid_in;
   logic [COORD_WIDTH-1:0]     x_in;
   logic [COORD_WIDTH-1:0]     y_in;
   logic [DEPTH_BIT_WIDTH-1:0] depth_in;
   logic [COLOR_WIDTH-1:0]     color_in;
   logic                       clear_start;
   logic                       ready_out;
   logic                       clear_done;
   logic [ADDR_WIDTH-1:0]      depth_raddr;
   logic [DEPTH_BIT_WIDTH-1:0] depth_rdata;
   logic                       depth_wen;
   logic [ADDR_WIDTH-1:0]      depth_waddr;
   logic [DEPTH_BIT_WIDTH-1:0] depth_wdata;
   logic                       fb_wen;
   logic [ADDR_WIDTH-1:0]      fb_waddr;
   logic [COLOR_WIDTH-1:0]     fb_wdata;

   modport slave (
      input  pixel_valid_in, x_in, y_in, depth_in, color_in, clear_start, depth_rdata,
      output ready_out, clear_done, depth_raddr, depth_wen, depth_waddr, depth_wdata,
             fb_wen, fb_waddr, fb_wdata
   );

   modport master (
      output pixel_valid_in, x_in, y_in, depth_in, color_in, clear_start, depth_rdata,
      input  ready_out, clear_done, depth_raddr, depth_wen, depth_waddr, depth_wdata,
             fb_wen, fb_waddr, fb_wdata
   );

endinterface
`default_nettype wire

// File: rtl/depth_test_writer_forward_buffer.sv
`default_nettype none
// =============================================================================
// depth_forward_buffer: history of recent depth writes with newest-match lookup.
// Rev 1.0
// =============================================================================
module depth_forward_buffer #(
   parameter int ADDR_WIDTH      = 16,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int ENTRIES         = 3
) (
   input  wire logic                       clk_in,
   input  wire logic                       rst_in,
   input  wire logic                       push_valid,
   input  wire logic [ADDR_WIDTH-1:0]      push_addr,
   input  wire logic [DEPTH_BIT_WIDTH-1:0] push_depth,
   input  wire logic [ADDR_WIDTH-1:0]      lookup_addr,
   output logic                            hit,
   output logic [DEPTH_BIT_WIDTH-1:0]      hit_depth
);
   logic [ENTRIES-1:0]                      vld_q,   vld_d;
   logic [ENTRIES-1:0][ADDR_WIDTH-1:0]      addr_q,  addr_d;
   logic [ENTRIES-1:0][DEPTH_BIT_WIDTH-1:0] depth_q, depth_d;

   // Shifts every cycle so entry i is always the write committed i cycles ago
   always_comb begin
      vld_d   = {vld_q[ENTRIES-2:0],   push_valid};
      addr_d  = {addr_q[ENTRIES-2:0],  push_addr};
      depth_d = {depth_q[ENTRIES-2:0], push_depth};
      hit       = 1'b0;
      hit_depth = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (vld_q[i] && (addr_q[i] == lookup_addr)) begin
            hit       = 1'b1;
            hit_depth = depth_q[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vld_q   <= '0;
         addr_q  <= '0;
         depth_q <= '0;
      end else begin
         vld_q   <= vld_d;
         addr_q  <= addr_d;
         depth_q <= depth_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/depth_test_writer.sv
`default_nettype none
// =============================================================================
// depth_test_writer: pipelined depth read-compare-write plus buffer clear sweep.
// Define DEPTH_TEST_STATS_EN for pass/reject/drop counters.  Rev 1.0
// =============================================================================
module depth_test_writer
   import depth_test_writer_pkg::*;
#(
   parameter int                     COORD_WIDTH     = 32,
   parameter int                     DEPTH_BIT_WIDTH = 16,
   parameter int                     COLOR_WIDTH     = 16,
   parameter int                     FB_WIDTH        = 320,
   parameter int                     FB_HEIGHT       = 180,
   parameter int                     BRAM_LATENCY    = 2,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR     = '0
) (
   input  wire logic          clk_in,
   input  wire logic          rst_in,
   depth_test_writer_if.slave bus
`ifdef DEPTH_TEST_STATS_EN
   ,
   output logic [31:0]        pass_count,
   output logic [31:0]        reject_count,
   output logic [31:0]        drop_count
`endif
);
   localparam int AW   = fb_addr_width(FB_WIDTH, FB_HEIGHT);
   localparam int NPIX = FB_WIDTH * FB_HEIGHT;
   localparam int L    = BRAM_LATENCY;

   logic [1:0]                      state_q, state_d;
   logic [AW-1:0]                   cnt_q, cnt_d;
   logic                            ready, clear_done_d, clear_done_q;
   logic                            x_ok, y_ok, accept;
   logic [AW-1:0]                   lin_addr;
   logic [L:0]                      st_valid_q, st_valid_d;
   logic [L:0][AW-1:0]              st_addr_q,  st_addr_d;
   logic [L:0][DEPTH_BIT_WIDTH-1:0] st_depth_q, st_depth_d;
   logic [L:0][COLOR_WIDTH-1:0]     st_color_q, st_color_d;
   logic                            fwd_hit, pass;
   logic [DEPTH_BIT_WIDTH-1:0]      fwd_depth, stored_depth;
   logic                            wen_q, wen_d;
   logic [AW-1:0]                   waddr_q, waddr_d;
   logic [DEPTH_BIT_WIDTH-1:0]      wdepth_q, wdepth_d;
   logic [COLOR_WIDTH-1:0]          wcolor_q, wcolor_d;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts drain cycles in DRAIN and the sweep address in CLEAR
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (bus.clear_start) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == AW'(L)) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == AW'(NPIX - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ready        = (state_q == ST_RUN);
      clear_done_d = (state_q == ST_CLEAR) && (cnt_q == AW'(NPIX - 1));
   end

   always_comb begin
      x_ok     = !bus.x_in[COORD_WIDTH-1] && (bus.x_in < COORD_WIDTH'(FB_WIDTH));
      y_ok     = !bus.y_in[COORD_WIDTH-1] && (bus.y_in < COORD_WIDTH'(FB_HEIGHT));
      accept   = ready && bus.pixel_valid_in;
      lin_addr = AW'(bus.y_in[AW-1:0] * AW'(FB_WIDTH)) + bus.x_in[AW-1:0];

      st_valid_d = {st_valid_q[L-1:0], accept && x_ok && y_ok};
      st_addr_d  = {st_addr_q[L-1:0],  lin_addr};
      st_depth_d = {st_depth_q[L-1:0], bus.depth_in};
      st_color_d = {st_color_q[L-1:0], bus.color_in};

      // Strict less-than: on equal depth the first-drawn sample keeps the pixel
      stored_depth = fwd_hit ? fwd_depth : bus.depth_rdata;
      pass         = st_valid_q[L] && (st_depth_q[L] < stored_depth);

      if (state_q == ST_CLEAR) begin
         wen_d    = 1'b1;
         waddr_d  = cnt_q;
         wdepth_d = '1;
         wcolor_d = CLEAR_COLOR;
      end else begin
         wen_d    = pass;
         waddr_d  = st_addr_q[L];
         wdepth_d = st_depth_q[L];
         wcolor_d = st_color_q[L];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         st_valid_q   <= '0;
         st_addr_q    <= '0;
         st_depth_q   <= '0;
         st_color_q   <= '0;
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         wdepth_q     <= '0;
         wcolor_q     <= '0;
         clear_done_q <= 1'b0;
      end else begin
         st_valid_q   <= st_valid_d;
         st_addr_q    <= st_addr_d;
         st_depth_q   <= st_depth_d;
         st_color_q   <= st_color_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         wdepth_q     <= wdepth_d;
         wcolor_q     <= wcolor_d;
         clear_done_q <= clear_done_d;
      end
   end

   depth_forward_buffer #(
      .ADDR_WIDTH      (AW),
      .DEPTH_BIT_WIDTH (DEPTH_BIT_WIDTH),
      .ENTRIES         (L + 1)
   ) u_fwd (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .push_valid  (wen_d),
      .push_addr   (waddr_d),
      .push_depth  (wdepth_d),
      .lookup_addr (st_addr_q[L]),
      .hit         (fwd_hit),
      .hit_depth   (fwd_depth)
   );

   assign bus.ready_out   = ready;
   assign bus.clear_done  = clear_done_q;
   assign bus.depth_raddr = st_addr_q[0];
   assign bus.depth_wen   = wen_q;
   assign bus.depth_waddr = waddr_q;
   assign bus.depth_wdata = wdepth_q;
   assign bus.fb_wen      = wen_q;
   assign bus.fb_waddr    = waddr_q;
   assign bus.fb_wdata    = wcolor_q;

`ifdef DEPTH_TEST_STATS_EN
   logic        drop, reject;
   logic [31:0] pass_cnt_q, pass_cnt_d, rej_cnt_q, rej_cnt_d, drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop       = bus.pixel_valid_in && !(ready && x_ok && y_ok);
      reject     = st_valid_q[L] && !pass;
      pass_cnt_d = pass_cnt_q;
      rej_cnt_d  = rej_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (clear_done_d) begin
         pass_cnt_d = '0;
         rej_cnt_d  = '0;
         drop_cnt_d = '0;
      end else begin
         if (pass   && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 1'b1;
         if (reject && (rej_cnt_q  != '1)) rej_cnt_d  = rej_cnt_q + 1'b1;
         if (drop   && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pass_cnt_q <= '0;
         rej_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         rej_cnt_q  <= rej_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pass_count   = pass_cnt_q;
   assign reject_count = rej_cnt_q;
   assign drop_count   = drop_cnt_q;
`endif

endmodule
`default_nettype wire
